// File: rtl/conv1d_pkg.sv
// Shared types and width helpers for the conv1d sequencer slice.
package conv1d_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } conv1d_state_t;

    function automatic int conv1d_tap_w(input int n_taps);
        return (n_taps < 2) ? 1 : $clog2(n_taps);
    endfunction

    // An index range of one still needs a one-bit port.
    function automatic int conv1d_out_w(input int n_out);
        return (n_out < 2) ? 1 : $clog2(n_out);
    endfunction

endpackage

// File: rtl/conv1d_if.sv
// Command, memory-read and result handshake bundle between the sequencer and its neighbours.
interface conv1d_if
    import conv1d_pkg::*;
#(
    parameter int N_TAPS = 8,
    parameter int N_OUT  = 16,
    parameter int ADDR_W = 8,
    parameter int TAP_W  = conv1d_tap_w(N_TAPS),
    parameter int OUT_W  = conv1d_out_w(N_OUT)
);
    logic              start;
    logic              abort;
    logic              out_ready;
    logic              busy;
    logic [ADDR_W-1:0] x_addr;
    logic [TAP_W-1:0]  w_addr;
    logic              rd_en;
    logic              acc_clr;
    logic              acc_en;
    logic              out_valid;
    logic [OUT_W-1:0]  out_addr;
    logic              done;

    modport master (
        input  start, abort, out_ready,
        output busy, x_addr, w_addr, rd_en, acc_clr, acc_en, out_valid, out_addr, done
    );

    modport slave (
        output start, abort, out_ready,
        input  busy, x_addr, w_addr, rd_en, acc_clr, acc_en, out_valid, out_addr, done
    );
endinterface

// File: rtl/conv1d_idx_counter.sv
// Modulo-MAX index counter with synchronous clear and a terminal-count flag.
module conv1d_idx_counter #(
    parameter int MAX = 8,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         terminal
);
    logic [W-1:0] value_r;

    assign value    = value_r;
    assign terminal = (value_r == W'(MAX - 1));

    // index register: clear wins over increment, wraps at MAX-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_r <= {W{1'b0}};
        end else if (clr) begin
            value_r <= {W{1'b0}};
        end else if (inc) begin
            value_r <= terminal ? {W{1'b0}} : value_r + W'(1);
        end else begin
            value_r <= value_r;
        end
    end
endmodule

// File: rtl/conv1d_ctrl.sv
// conv1d sequencer: walks taps and outputs, drives memory reads, accumulator control
// and the result handshake. Every output is a flop loaded from the next-state decode.
module conv1d_ctrl
    import conv1d_pkg::*;
#(
    parameter int N_TAPS = 8,
    parameter int N_OUT  = 16,
    parameter int ADDR_W = 8
) (
    input  logic     clk,
    input  logic     reset,
    conv1d_if.master bus
);
    localparam int TAP_W = conv1d_tap_w(N_TAPS);
    localparam int OUT_W = conv1d_out_w(N_OUT);

    if (((N_OUT + N_TAPS - 2) >> ADDR_W) != 0) begin : g_addr_range_chk
        $error("conv1d_ctrl: ADDR_W cannot hold N_OUT+N_TAPS-2");
    end

    conv1d_state_t     state_r, state_nxt_s;
    logic [TAP_W-1:0]  k_s, k_nxt_s;
    logic [OUT_W-1:0]  j_s, j_nxt_s;
    logic              k_term_s, k_clr_s, k_inc_s;
    logic              j_term_s, j_clr_s, j_inc_s;
    logic              busy_r, rd_en_r, acc_clr_r, acc_en_r, out_valid_r, done_r;
    logic [ADDR_W-1:0] x_addr_r;
    logic [TAP_W-1:0]  w_addr_r;
    logic [OUT_W-1:0]  out_addr_r;

    conv1d_idx_counter #(.MAX(N_TAPS), .W(TAP_W)) u_k_cnt (
        .clk(clk), .reset(reset), .clr(k_clr_s), .inc(k_inc_s), .value(k_s), .terminal(k_term_s)
    );

    conv1d_idx_counter #(.MAX(N_OUT), .W(OUT_W)) u_j_cnt (
        .clk(clk), .reset(reset), .clr(j_clr_s), .inc(j_inc_s), .value(j_s), .terminal(j_term_s)
    );

    // next-state and index-control decode; abort overrides every transition
    always_comb begin
        state_nxt_s = state_r;
        k_clr_s     = 1'b0;
        k_inc_s     = 1'b0;
        j_clr_s     = 1'b0;
        j_inc_s     = 1'b0;
        if (bus.abort) begin
            state_nxt_s = S_IDLE;
            k_clr_s     = 1'b1;
            j_clr_s     = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        state_nxt_s = S_CLR;
                        k_clr_s     = 1'b1;
                        j_clr_s     = 1'b1;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_CLR: begin
                    k_clr_s     = 1'b1;
                    state_nxt_s = S_MAC;
                end
                S_MAC: begin
                    if (k_term_s) begin
                        k_clr_s     = 1'b1;
                        state_nxt_s = S_DRAIN;
                    end else begin
                        k_inc_s     = 1'b1;
                        state_nxt_s = S_MAC;
                    end
                end
                S_DRAIN: state_nxt_s = S_WRITE;
                S_WRITE: begin
                    if (!bus.out_ready) begin
                        state_nxt_s = S_WRITE;
                    end else if (j_term_s) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        j_inc_s     = 1'b1;
                        state_nxt_s = S_CLR;
                    end
                end
                S_DONE: begin
                    k_clr_s     = 1'b1;
                    j_clr_s     = 1'b1;
                    state_nxt_s = S_IDLE;
                end
                default: begin
                    k_clr_s     = 1'b1;
                    j_clr_s     = 1'b1;
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // index values the counters will hold next cycle, so outputs can be registered
    always_comb begin
        if (k_clr_s) begin
            k_nxt_s = {TAP_W{1'b0}};
        end else if (k_inc_s) begin
            k_nxt_s = k_term_s ? {TAP_W{1'b0}} : k_s + TAP_W'(1);
        end else begin
            k_nxt_s = k_s;
        end
        if (j_clr_s) begin
            j_nxt_s = {OUT_W{1'b0}};
        end else if (j_inc_s) begin
            j_nxt_s = j_term_s ? {OUT_W{1'b0}} : j_s + OUT_W'(1);
        end else begin
            j_nxt_s = j_s;
        end
    end

    // state and output registers; acc_en trails rd_en by the memory read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            x_addr_r    <= {ADDR_W{1'b0}};
            w_addr_r    <= {TAP_W{1'b0}};
            acc_clr_r   <= 1'b0;
            acc_en_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_addr_r  <= {OUT_W{1'b0}};
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != S_IDLE);
            rd_en_r     <= (state_nxt_s == S_MAC);
            x_addr_r    <= (state_nxt_s == S_MAC) ? ADDR_W'(j_nxt_s) + ADDR_W'(k_nxt_s) : {ADDR_W{1'b0}};
            w_addr_r    <= (state_nxt_s == S_MAC) ? k_nxt_s : {TAP_W{1'b0}};
            acc_clr_r   <= (state_nxt_s == S_CLR);
            acc_en_r    <= rd_en_r & ~bus.abort;
            out_valid_r <= (state_nxt_s == S_WRITE);
            out_addr_r  <= (state_nxt_s == S_WRITE) ? j_nxt_s : {OUT_W{1'b0}};
            done_r      <= (state_nxt_s == S_DONE);
        end
    end

    assign bus.busy      = busy_r;
    assign bus.rd_en     = rd_en_r;
    assign bus.x_addr    = x_addr_r;
    assign bus.w_addr    = w_addr_r;
    assign bus.acc_clr   = acc_clr_r;
    assign bus.acc_en    = acc_en_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_addr  = out_addr_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_conv1d_ctrl.sv
// Directed bench for conv1d_ctrl: a 4-tap/3-output instance and a 2-tap/1-output instance.
module tb_conv1d_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks_cnt = 0;
    int   errors_cnt = 0;
    logic [31:0] b_exp [0:7];

    always #5 clk = ~clk;

    conv1d_if #(.N_TAPS(4), .N_OUT(3), .ADDR_W(8)) a_if ();
    conv1d_if #(.N_TAPS(2), .N_OUT(1), .ADDR_W(8)) b_if ();

    conv1d_ctrl #(.N_TAPS(4), .N_OUT(3), .ADDR_W(8)) u_dut_a (.clk(clk), .reset(reset), .bus(a_if));
    conv1d_ctrl #(.N_TAPS(2), .N_OUT(1), .ADDR_W(8)) u_dut_b (.clk(clk), .reset(reset), .bus(b_if));

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // {busy, rd_en, acc_clr, acc_en, out_valid, done} then x_addr, w_addr, out_addr bytes
    function automatic logic [31:0] pack(input logic busy, input logic rd, input logic clr,
                                         input logic en, input logic ov, input logic dn,
                                         input logic [7:0] x, input logic [7:0] w, input logic [7:0] oa);
        return {2'b00, busy, rd, clr, en, ov, dn, x, w, oa};
    endfunction

    function automatic logic [31:0] obs_a();
        return pack(a_if.busy, a_if.rd_en, a_if.acc_clr, a_if.acc_en, a_if.out_valid, a_if.done,
                    a_if.x_addr, 8'(a_if.w_addr), 8'(a_if.out_addr));
    endfunction

    function automatic logic [31:0] obs_b();
        return pack(b_if.busy, b_if.rd_en, b_if.acc_clr, b_if.acc_en, b_if.out_valid, b_if.done,
                    b_if.x_addr, 8'(b_if.w_addr), 8'(b_if.out_addr));
    endfunction

    // expected 4-tap/3-output trace, start sampled in cycle 0, out_ready high
    function automatic logic [31:0] exp_a(input int c);
        int n;
        int p;
        if (c >= 1 && c <= 21) begin
            n = (c - 1) / 7;
            p = (c - 1) % 7;
            if (p == 0)      return pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
            else if (p <= 4) return pack(1'b1, 1'b1, 1'b0, (p >= 2), 1'b0, 1'b0, 8'(n + p - 1), 8'(p - 1), 8'd0);
            else if (p == 5) return pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
            else             return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'(n));
        end else if (c == 22) begin
            return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        end else begin
            return 32'h0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input string tag, input bit restart);
        check_value($sformatf("%s c0", tag), obs_a(), exp_a(0));
        a_if.start = 1'b1;
        step();
        for (int c = 1; c <= 26; c++) begin
            check_value($sformatf("%s c%0d", tag, c), obs_a(), exp_a(c));
            a_if.start = restart && (c == 3 || c == 22);
            step();
        end
        a_if.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        b_exp[0] = 32'h0;
        b_exp[1] = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        b_exp[2] = pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        b_exp[3] = pack(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 8'd0);
        b_exp[4] = pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        b_exp[5] = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        b_exp[6] = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        b_exp[7] = 32'h0;

        reset        = 1'b1;
        a_if.start   = 1'b0;
        a_if.abort   = 1'b0;
        a_if.out_ready = 1'b1;
        b_if.start   = 1'b0;
        b_if.abort   = 1'b0;
        b_if.out_ready = 1'b1;
        step();
        step();
        check_value("reset_a", obs_a(), 32'h0);
        check_value("reset_b", obs_b(), 32'h0);
        reset = 1'b0;
        step();

        // nominal run
        run_a("nominal", 1'b0);

        // backpressure: ready low for cycles 7..11 of the first WRITE
        a_if.out_ready = 1'b0;
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
        for (int c = 1; c <= 28; c++) begin
            if (c >= 7 && c <= 12)
                check_value($sformatf("bp_hold c%0d", c), obs_a(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
            if (c == 13)
                check_value("bp_clr", obs_a(), pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
            if (c == 14)
                check_value("bp_mac", obs_a(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0));
            if (c == 19)
                check_value("bp_out1", obs_a(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd1));
            if (c == 27)
                check_value("bp_done", obs_a(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0));
            if (c == 28)
                check_value("bp_idle", obs_a(), 32'h0);
            a_if.out_ready = (c >= 12);
            step();
        end
        a_if.out_ready = 1'b1;

        // start re-asserted in MAC and in DONE must not disturb the trace
        run_a("restart_ignored", 1'b1);

        // abort in the second MAC cycle of output 1
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            check_value($sformatf("abort c%0d", c), obs_a(), (c <= 10) ? exp_a(c) : 32'h0);
            a_if.abort = (c == 10);
            step();
        end
        a_if.abort = 1'b0;
        run_a("after_abort", 1'b0);

        // async reset between clock edges during a held WRITE
        a_if.out_ready = 1'b0;
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
        for (int c = 1; c < 7; c++) step();
        check_value("rst_pre_write", obs_a(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
        step();
        #2;
        reset = 1'b1;
        #1;
        check_value("rst_async", obs_a(), 32'h0);
        #1;
        reset = 1'b0;
        a_if.out_ready = 1'b1;
        step();
        check_value("rst_idle", obs_a(), 32'h0);
        run_a("post_reset", 1'b0);

        // single output, two taps
        check_value("b c0", obs_b(), b_exp[0]);
        b_if.start = 1'b1;
        step();
        b_if.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            check_value($sformatf("b c%0d", c), obs_b(), b_exp[c]);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
